// File: rtl/pipelined_addsub.sv
// pipelined_addsub
//
// Pipelined two's-complement adder/subtractor for the ALU datapath.
// The WIDTH-bit operation is split into STAGES chunks of CHUNK bits each.
// Stage k resolves chunk k and registers its carry for stage k+1. The longest
// combinational path is therefore one CHUNK-bit ripple rather than a
// WIDTH-bit ripple.
//
// Parameters
//   WIDTH      operand/result width in bits
//   STAGES     pipeline depth; must divide WIDTH exactly
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-low reset (0 = reset)
//   in_valid   operand bundle presented
//   in_ready   bundle is accepted this cycle (= !out_valid | out_ready)
//   a, b       operands
//   sub        0 = a + b, 1 = a - b
//   out_valid  result and flags are valid
//   out_ready  consumer takes the result this cycle
//   result     sum or difference, modulo 2^WIDTH
//   cout       carry out of the MSB (for subtract, 1 = no borrow)
//   overflow   signed overflow
//   negative   result MSB
//   zero       result == 0
module pipelined_addsub #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             negative,
    output logic             zero
);

    localparam int CHUNK = WIDTH / STAGES;

    if ((STAGES < 1) || (WIDTH % STAGES != 0)) begin : g_param_check
        $error("pipelined_addsub: STAGES must be >= 1 and divide WIDTH exactly");
    end

    // One pipeline register set per stage. The operand fields carry the
    // still-unresolved upper bits forward. The res field accumulates the
    // completed lower bits. carry is the carry out of this stage's chunk.
    // c_msb_in is meaningful only in the final stage.
    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] opa;
        logic [WIDTH-1:0] opb;
        logic [WIDTH-1:0] res;
        logic             carry;
        logic             zero;
        logic             c_msb_in;
    } stage_t;

    stage_t stage_q [STAGES];
    stage_t stage_d [STAGES];
    stage_t src;
    logic [CHUNK:0] csum;
    logic advance;

    // The whole pipeline moves as one unit. While the final stage holds an
    // unconsumed result, everything freezes, including bubbles.
    assign advance  = !stage_q[STAGES-1].vld | out_ready;
    assign in_ready = advance;

    // Next-state value for every stage. Stage 0 takes the pre-inverted B
    // operand and uses carry-in = sub. Each later stage adds its chunk using
    // the carry registered by the stage before it.
    always_comb begin
        src  = '0;
        csum = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                src.vld      = in_valid;
                src.opa      = a;
                src.opb      = b ^ {WIDTH{sub}};
                src.res      = '0;
                src.carry    = sub;
                src.zero     = 1'b1;
                src.c_msb_in = 1'b0;
            end else begin
                src = stage_q[(k == 0) ? 0 : k - 1];
            end
            csum = {1'b0, src.opa[k*CHUNK +: CHUNK]}
                 + {1'b0, src.opb[k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, src.carry};
            stage_d[k]                        = src;
            stage_d[k].res[k*CHUNK +: CHUNK]  = csum[CHUNK-1:0];
            stage_d[k].carry                  = csum[CHUNK];
            stage_d[k].zero                   = src.zero & (csum[CHUNK-1:0] == '0);
            // The carry into a bit position equals sum ^ a ^ b at that
            // position. Applied to the top bit of the chunk, this gives the
            // carry into the MSB for the final stage.
            stage_d[k].c_msb_in = csum[CHUNK-1]
                                ^ src.opa[k*CHUNK + CHUNK - 1]
                                ^ src.opb[k*CHUNK + CHUNK - 1];
        end
    end

    // Only valid operations overwrite a stage's payload. As a result, the
    // final-stage result and flags keep their last values across bubbles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                if (stage_d[k].vld) begin
                    stage_q[k] <= stage_d[k];
                end else begin
                    stage_q[k].vld <= 1'b0;
                end
            end
        end
    end

    assign out_valid = stage_q[STAGES-1].vld;
    assign result    = stage_q[STAGES-1].res;
    assign cout      = stage_q[STAGES-1].carry;
    assign overflow  = stage_q[STAGES-1].carry ^ stage_q[STAGES-1].c_msb_in;
    assign negative  = stage_q[STAGES-1].res[WIDTH-1];
    assign zero      = stage_q[STAGES-1].zero;

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub
//
// Self-checking bench for pipelined_addsub with WIDTH=64 and STAGES=4.
// A table of directed vectors checks exact values and latency. A
// negedge monitor compares every output handshake against a plain-arithmetic
// reference model held in an expected-result queue. The monitor also checks
// the ready rule and output stability during stalls.
module tb_pipelined_addsub;

    localparam int W = 64;
    localparam int S = 4;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;
    logic         negative;
    logic         zero;

    pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .overflow  (overflow),
        .negative  (negative),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
        logic         neg;
        logic         zero;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        exp_t         exp;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    int   n_out    = 0;
    exp_t exp_q [$];
    vec_t vecs [8];

    logic stall_prev = 1'b0;
    exp_t stall_saved;

    // Reference model: plain wide arithmetic. Signed overflow uses the
    // textbook rule: the operands have the same sign and the sum's sign differs.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        logic [W:0]   full;
        logic [W-1:0] yy;
        exp_t         e;
        yy     = s ? ~y : y;
        full   = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, s};
        e.res  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
        e.neg  = full[W-1];
        e.zero = (full[W-1:0] == '0);
        return e;
    endfunction

    task automatic check_output(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        in_valid = v;
        a        = x;
        b        = y;
        sub      = s;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Output-side monitor. It samples at the falling edge, which is half a
    // cycle away from the edge where the handshakes it sees take effect.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            check_bit("in_ready_rule", in_ready, !(out_valid && !out_ready));
            if (stall_prev) begin
                check_bit("stall_valid", out_valid, 1'b1);
                check_output("stall_result", result, stall_saved.res);
                check_bit("stall_flags_cout", cout, stall_saved.cout);
                check_bit("stall_flags_ovf", overflow, stall_saved.ovf);
                check_bit("stall_flags_zero", zero, stall_saved.zero);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_output: got result 0x%0h, expected no output", result);
                end else begin
                    e = exp_q.pop_front();
                    check_output("model_result", result, e.res);
                    check_bit("model_cout", cout, e.cout);
                    check_bit("model_overflow", overflow, e.ovf);
                    check_bit("model_negative", negative, e.neg);
                    check_bit("model_zero", zero, e.zero);
                    n_out++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, sub));
            end
            stall_prev        = out_valid && !out_ready;
            stall_saved.res   = result;
            stall_saved.cout  = cout;
            stall_saved.ovf   = overflow;
            stall_saved.neg   = negative;
            stall_saved.zero  = zero;
        end
    end

    // Sends one directed vector into an empty pipeline and checks the
    // latency and the exact outputs from the table.
    task automatic run_vector(input int i);
        int lat;
        out_ready = 1'b1;
        apply_stimulus(1'b1, vecs[i].a, vecs[i].b, vecs[i].sub);
        next_cycle();
        apply_stimulus(1'b0, '0, '0, 1'b0);
        lat = 1;
        while (!out_valid && lat < 20) begin
            next_cycle();
            lat++;
        end
        check_output($sformatf("latency[%0d]", i), 64'(lat), 64'(S));
        check_output($sformatf("result[%0d]", i), result, vecs[i].exp.res);
        check_bit($sformatf("cout[%0d]", i), cout, vecs[i].exp.cout);
        check_bit($sformatf("overflow[%0d]", i), overflow, vecs[i].exp.ovf);
        check_bit($sformatf("negative[%0d]", i), negative, vecs[i].exp.neg);
        check_bit($sformatf("zero[%0d]", i), zero, vecs[i].exp.zero);
        next_cycle();
    endtask

    initial begin
        int idx;
        int cyc;
        int start_out;

        // Vector fields: a, b, sub, then {result, cout, overflow, negative, zero}.
        vecs[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, '{64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, '{64'h0, 1'b1, 1'b0, 1'b0, 1'b1}};
        vecs[2] = '{64'h5, 64'h5, 1'b1, '{64'h0, 1'b1, 1'b0, 1'b0, 1'b1}};
        vecs[3] = '{64'h3, 64'h5, 1'b1, '{64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0}};
        vecs[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, '{64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1, 1'b0}};
        vecs[5] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, '{64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0}};
        vecs[6] = '{64'h0000_0001_0000_0000, 64'h1, 1'b1, '{64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0}};
        vecs[7] = '{64'h0, 64'h0, 1'b1, '{64'h0, 1'b1, 1'b0, 1'b0, 1'b1}};

        // Reset held for three cycles with a valid bundle presented.
        reset     = 1'b0;
        out_ready = 1'b1;
        apply_stimulus(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
        repeat (3) next_cycle();
        check_bit("reset_out_valid", out_valid, 1'b0);
        check_output("reset_result", result, '0);
        check_bit("reset_cout", cout, 1'b0);
        check_bit("reset_overflow", overflow, 1'b0);
        check_bit("reset_negative", negative, 1'b0);
        check_bit("reset_zero", zero, 1'b0);
        reset = 1'b1;
        apply_stimulus(1'b0, '0, '0, 1'b0);
        check_bit("post_reset_in_ready", in_ready, 1'b1);
        for (int i = 0; i < S; i++) begin
            next_cycle();
            check_bit("post_reset_quiet", out_valid, 1'b0);
        end

        // Directed vectors.
        for (int i = 0; i < 8; i++) begin
            run_vector(i);
        end

        // Back-to-back random operations with random backpressure.
        idx       = 0;
        cyc       = 0;
        start_out = n_out;
        while ((n_out - start_out < 8) && cyc < 400) begin
            out_ready = ($urandom_range(0, 2) != 0);
            if (idx < 8) begin
                apply_stimulus(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
            end else begin
                apply_stimulus(1'b0, '0, '0, 1'b0);
            end
            #1;
            if (in_valid && in_ready) idx++;
            next_cycle();
            cyc++;
        end
        check_output("stream_count", 64'(n_out - start_out), 64'd8);
        check_output("stream_queue_empty", 64'(exp_q.size()), 64'd0);
        apply_stimulus(1'b0, '0, '0, 1'b0);
        out_ready = 1'b1;
        next_cycle();

        // Three operations in flight, then a one-cycle reset discards them.
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
            next_cycle();
        end
        apply_stimulus(1'b0, '0, '0, 1'b0);
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
        check_bit("midflight_out_valid", out_valid, 1'b0);
        check_output("midflight_result", result, '0);
        for (int i = 0; i < 6; i++) begin
            check_bit("midflight_no_ghost", out_valid, 1'b0);
            next_cycle();
        end
        run_vector(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined adder/subtractor for the ALU datapath of the pipelined processor.
- The WIDTH-bit operation is split into STAGES carry-chained chunks, with one chunk resolved per cycle.
- Carry and zero information is registered between stages, so the critical path is one CHUNK-bit ripple, not WIDTH bits.
- Produces result plus negative/zero/overflow/carry flags behind a valid/ready handshake.

Parameters:
- WIDTH, 64, operand/result width in bits.
- STAGES, 4, number of pipeline stages; must divide WIDTH exactly (elaboration error otherwise).
- CHUNK, WIDTH/STAGES, derived bits resolved per stage; not overridable.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- in_valid  input  1  operand bundle presented.
- in_ready  output  1  block accepts the bundle this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0 = A+B; 1 = A-B (B inverted, carry-in 1).
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  sum/difference, two's complement.
- cout  output  1  carry out of the MSB; for subtract, 1 = no borrow.
- overflow  output  1  signed overflow (carry into MSB XOR carry out of MSB).
- negative  output  1  result[WIDTH-1].
- zero  output  1  result == 0.

Behaviour:
- Reset (reset=0 at a rising edge): all stage valid bits, result, and flags are cleared to 0; in_ready reads 1 once reset deasserts.
  - Operations in flight are discarded, never emitted.
  - Reset overrides every other input.
- Global advance signal: advance = !out_valid | out_ready, and in_ready = advance.
  - When advance=0, every stage register holds, including bubbles.
  - Accept occurs when in_valid & in_ready.
- Stage 0 on accept:
  - Latches a and (b XOR {WIDTH{sub}}), with carry-in = sub.
  - Computes chunk 0 (bits CHUNK-1:0), its carry out, and a chunk-zero flag.
  - If in_valid=0 while advancing, a bubble (valid=0) enters.
- Stage k (1..STAGES-1):
  - Adds chunk k of the carried operands using the registered carry from stage k-1.
  - Passes down the completed lower result bits and the remaining upper operand bits.
  - AND-accumulates the zero flag.
- Final stage:
  - Also registers the carry into the MSB and the carry out of the MSB, forming cout and overflow.
  - negative = result MSB.
  - Outputs are driven directly from the final-stage registers (no combinational path from a/b).
- Latency: exactly STAGES cycles from accept to out_valid with no stall; STAGES=1 gives a 1-cycle registered adder.
- Throughput: one operation per cycle while out_ready=1. Results leave in accept order with no loss or duplication.
- Stall: while out_valid=1 and out_ready=0, all outputs stay stable and in_ready=0.
- Inputs are sampled only on accept. a, b, and sub may change freely otherwise.
- When out_valid=0, result and flags hold their last values. Checkers must ignore them.
- Simultaneous out handshake and new accept in the same cycle: both occur and the pipeline shifts by one.
- Arithmetic is modulo 2^WIDTH. No saturation.

Test Plan (WIDTH=64, STAGES=4):
- Reset: hold reset=0 for 3 cycles with in_valid=1 -> out_valid=0, result=0, all flags 0. After release, in_ready=1 and no output appears for 4 cycles.
- Chunk carry: a=0x0000_0000_0000_FFFF, b=1, sub=0 -> 4 cycles later result=0x0000_0000_0001_0000, cout=0, zero=0, overflow=0. Also a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> result=0, cout=1, zero=1, overflow=0.
- Subtract: 5-5 -> result=0, zero=1, cout=1, negative=0. 3-5 -> result=0xFFFF_FFFF_FFFF_FFFE, negative=1, cout=0, overflow=0.
- Signed overflow: 0x7FFF_FFFF_FFFF_FFFF+1 -> 0x8000_0000_0000_0000, overflow=1, negative=1, cout=0. 0x8000_0000_0000_0000-1 -> 0x7FFF_FFFF_FFFF_FFFF, overflow=1, cout=1.
- Streaming/backpressure: 8 back-to-back random ops with out_ready toggling pseudo-randomly -> all 8 results match the reference model in order. in_ready=0 exactly when out_valid=1 and out_ready=0, and outputs are stable during the stall.
- Reset mid-flight: 3 ops accepted, then reset=0 for 1 cycle -> out_valid=0 the next cycle, none of the 3 results ever appears, and a new op after release returns a correct result after 4 cycles.
